rv32i_multicycle_ctrl: RTL

- Multi-cycle control FSM for the non-pipelined RV32I core.
- Sequences one instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the instruction-register latch, register-file read/write enables, PC update, ALU/write-back selects and the data-memory handshake.
- Sits beside the decode unit and register file, and consumes the latched IR and the branch-compare result.

---
 rtl/rv32i_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the non-pipelined RV32I core.
// Optional stall counter is built only when RV_CTRL_PERF_EN is defined.
module rv32i_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic [31:0]      ir,
  output logic             rf_re,
  output logic             rf_we,
  output logic [1:0]       alu_sel,
  output logic             alu_src_imm,
  input  logic             br_taken,
  output logic             pc_we,
  output logic             pc_src,
  output logic [1:0]       wb_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;

  localparam logic [7:0]       TO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic       wait_cyc;
  logic       timeout;
  logic       set_illegal;
  logic [6:0] opcode;
  logic       rd_zero;
  logic       unused_ir;

  assign state     = cur;
  assign opcode    = ir[6:0];
  assign rd_zero   = (ir[11:7] == 5'd0);
  assign unused_ir = ^ir[31:12];

  // Handshake: a request stays high while its state holds; ready completes it in the same cycle.
  always_comb begin
    nxt         = cur;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    rf_re       = 1'b0;
    rf_we       = 1'b0;
    alu_sel     = 2'b00;
    alu_src_imm = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    wb_sel      = 2'b00;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    wait_cyc    = 1'b0;
    timeout     = 1'b0;
    set_illegal = 1'b0;
    case (cur)
      S_FETCH: begin
        if (en) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we = 1'b1;
            nxt   = S_DECODE;
          end else begin
            wait_cyc = 1'b1;
            if (wait_cnt == TO_LAST) begin
              timeout = 1'b1;
              nxt     = S_TRAP;
            end
          end
        end
      end
      S_DECODE: begin
        rf_re = 1'b1;
        case (opcode)
          OP_R, OP_I, OP_L, OP_S, OP_B, OP_J: nxt = S_EXEC;
          default: begin
            set_illegal = 1'b1;
            nxt         = S_TRAP;
          end
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_sel = 2'b01;
            nxt     = S_WB;
          end
          OP_I: begin
            alu_sel     = 2'b01;
            alu_src_imm = 1'b1;
            nxt         = S_WB;
          end
          OP_L, OP_S: begin
            alu_src_imm = 1'b1;
            nxt         = S_MEM;
          end
          OP_B: begin
            alu_sel = 2'b10;
            pc_we   = 1'b1;
            pc_src  = br_taken;
            nxt     = S_FETCH;
          end
          OP_J:    nxt = S_WB;
          default: nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_S);
        if (dmem_ready) begin
          if (opcode == OP_S) begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else begin
          wait_cyc = 1'b1;
          if (wait_cnt == TO_LAST) begin
            timeout = 1'b1;
            nxt     = S_TRAP;
          end
        end
      end
      S_WB: begin
        rf_we = ~rd_zero;
        pc_we = 1'b1;
        case (opcode)
          OP_L: wb_sel = 2'b01;
          OP_J: begin
            wb_sel = 2'b10;
            pc_src = 1'b1;
          end
          default: wb_sel = 2'b00;
        endcase
        nxt = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  // wait_cnt restarts whenever a state is entered, so each handshake gets a fresh budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur      <= S_FETCH;
      wait_cnt <= 8'd0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      retired  <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= 8'd0;
      else if (wait_cyc)
        wait_cnt <= wait_cnt + 8'd1;
      if (set_illegal)
        illegal <= 1'b1;
      if (timeout)
        bus_err <= 1'b1;
      if (pc_we)
        retired <= retired + CNT_ONE;
    end
  end

`ifdef RV_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (((imem_req & ~imem_ready) | (dmem_req & ~dmem_ready)) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_ONE;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
